// File: rtl/loader_defs_pkg.sv
// Shared definitions for the program memory loader: FSM state encoding,
// frame sync byte and length-field width.
package loader_defs;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } loader_state_e;

   localparam logic [7:0]  LOADER_SYNC_BYTE = 8'hA5;
   localparam int unsigned LOADER_LEN_WIDTH = 16;

endpackage

// File: rtl/loader_word_packer.sv
// Little-endian byte packer: shifts accepted bytes into a DATA_WIDTH-bit word
// and flags (combinationally) the byte that completes a word. word_o is only
// meaningful while word_valid_o is high; the caller registers it.
module loader_word_packer #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  byte_en,
   input  logic [7:0]            byte_i,
   output logic                  word_valid_o,
   output logic [DATA_WIDTH-1:0] word_o
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [DATA_WIDTH-1:0] shifted;

   // Newest byte enters at the top so byte0 ends up in [7:0] once the word is full
   generate
      if (BYTES == 1) begin : g_single
         always_comb shifted = byte_i;
      end else begin : g_multi
         always_comb shifted = {byte_i, shreg_q[DATA_WIDTH-1:8]};
      end
   endgenerate

   // Byte counter and shift register next-state; flag the word-completing byte
   always_comb begin
      cnt_d        = cnt_q;
      shreg_d      = shreg_q;
      word_valid_o = 1'b0;
      word_o       = shifted;
      if (clear) begin
         cnt_d = '0;
      end else if (byte_en) begin
         shreg_d = shifted;
         if (cnt_q == CW'(BYTES - 1)) begin
            cnt_d        = '0;
            word_valid_o = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Packer state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         shreg_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
      end
   end

endmodule

// File: rtl/program_memory_loader.sv
// Program memory loader: parses A5/LEN_LO/LEN_HI/payload frames from a byte
// stream, writes packed instructions to program RAM and holds the core in
// reset until a good frame has been loaded.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module program_memory_loader
   import loader_defs::*;
#(
   parameter  int unsigned MEMORY_DEPTH = 64,
   parameter  int unsigned DATA_WIDTH   = 32,
   localparam int unsigned ADDR_WIDTH   = $clog2(MEMORY_DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            Byte_i,
   input  logic                  Byte_Valid_i,
   output logic                  Byte_Ready_o,
   output logic                  Wr_En_o,
   output logic [ADDR_WIDTH-1:0] Wr_Addr_o,
   output logic [DATA_WIDTH-1:0] Wr_Data_o,
   output logic                  Cpu_Reset_o,
   output logic                  Load_Done_o,
   output logic                  Load_Error_o
);

   localparam int unsigned     LW        = LOADER_LEN_WIDTH;
   localparam logic [LW-1:0]   DEPTH_LEN = LW'(MEMORY_DEPTH);

   loader_state_e         state_q, state_d;
   logic [7:0]            len_lo_q, len_lo_d;
   logic [LW-1:0]         len_q, len_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  cpu_reset_q, cpu_reset_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]            chk_q, chk_d;
`else
   logic                  last_q, last_d;
`endif

   logic                  accept;
   logic                  pk_en;
   logic                  pk_clear;
   logic                  pk_valid;
   logic [DATA_WIDTH-1:0] pk_word;
   logic [LW-1:0]         len_n;
   logic                  last_word;

   assign Byte_Ready_o = 1'b1;
   assign accept       = Byte_Valid_i;

   // Packer control kept apart from the FSM block to avoid a combinational
   // loop through the packer's word_valid output
   always_comb begin
      pk_clear = accept && (state_q == ST_LEN_HI);
`ifdef LOADER_CHECKSUM_EN
      pk_en    = accept && (state_q == ST_DATA);
`else
      pk_en    = accept && (state_q == ST_DATA) && !last_q;
`endif
   end

   loader_word_packer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_packer (
      .clk          (clk),
      .reset        (reset),
      .clear        (pk_clear),
      .byte_en      (pk_en),
      .byte_i       (Byte_i),
      .word_valid_o (pk_valid),
      .word_o       (pk_word)
   );

   // Frame FSM, address counter, length check and checksum next-state
   always_comb begin
      state_d     = state_q;
      len_lo_d    = len_lo_q;
      len_d       = len_q;
      addr_d      = addr_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      cpu_reset_d = cpu_reset_q;
      done_d      = done_q;
      error_d     = error_q;
`ifdef LOADER_CHECKSUM_EN
      chk_d       = chk_q;
`else
      last_d      = last_q;
`endif
      len_n       = {Byte_i, len_lo_q};
      last_word   = (LW'(addr_q) == (len_q - 1'b1));

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (accept && (Byte_i == LOADER_SYNC_BYTE)) begin
               state_d     = ST_LEN_LO;
               cpu_reset_d = 1'b1;
               done_d      = 1'b0;
               error_d     = 1'b0;
            end
         end
         ST_LEN_LO: begin
            if (accept) begin
               len_lo_d = Byte_i;
               state_d  = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (accept) begin
               if ((len_n == '0) || (len_n > DEPTH_LEN)) begin
                  state_d = ST_ERROR;
                  error_d = 1'b1;
               end else begin
                  state_d = ST_DATA;
                  len_d   = len_n;
                  addr_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                  chk_d   = '0;
`else
                  last_d  = 1'b0;
`endif
               end
            end
         end
         ST_DATA: begin
`ifdef LOADER_CHECKSUM_EN
            if (accept) begin
               chk_d = chk_q ^ Byte_i;
            end
`else
            // The final strobe is on the outputs now; DONE follows it by one cycle
            if (last_q) begin
               state_d     = ST_DONE;
               cpu_reset_d = 1'b0;
               done_d      = 1'b1;
            end
`endif
            if (pk_valid) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = pk_word;
               if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                  state_d = ST_CHECK;
`else
                  last_d  = 1'b1;
`endif
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (accept) begin
               if (Byte_i == chk_q) begin
                  state_d     = ST_DONE;
                  cpu_reset_d = 1'b0;
                  done_d      = 1'b1;
               end else begin
                  state_d = ST_ERROR;
                  error_d = 1'b1;
               end
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Loader state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         len_lo_q    <= '0;
         len_q       <= '0;
         addr_q      <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         chk_q       <= '0;
`else
         last_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         len_lo_q    <= len_lo_d;
         len_q       <= len_d;
         addr_q      <= addr_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         cpu_reset_q <= cpu_reset_d;
         done_q      <= done_d;
         error_q     <= error_d;
`ifdef LOADER_CHECKSUM_EN
         chk_q       <= chk_d;
`else
         last_q      <= last_d;
`endif
      end
   end

   assign Wr_En_o      = wr_en_q;
   assign Wr_Addr_o    = wr_addr_q;
   assign Wr_Data_o    = wr_data_q;
   assign Cpu_Reset_o  = cpu_reset_q;
   assign Load_Done_o  = done_q;
   assign Load_Error_o = error_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Directed, table-driven bench for program_memory_loader.
module tb_program_memory_loader;

   localparam int unsigned DEPTH = 64;
   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 6;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    Byte_i = '0;
   logic          Byte_Valid_i = 1'b0;
   logic          Byte_Ready_o;
   logic          Wr_En_o;
   logic [AW-1:0] Wr_Addr_o;
   logic [DW-1:0] Wr_Data_o;
   logic          Cpu_Reset_o;
   logic          Load_Done_o;
   logic          Load_Error_o;

   int unsigned checks = 0;
   int unsigned failures = 0;
   int unsigned cyc = 0;
   int unsigned last_acc = 0;

   logic [AW-1:0] wa[$];
   logic [DW-1:0] wd[$];
   int unsigned   wc[$];

   typedef struct {
      logic [15:0]       len;
      logic [3:0][31:0]  w;
      int unsigned       gap;
      bit                junk;
      bit                exp_done;
      bit                exp_err;
      int unsigned       exp_nwr;
   } vec_t;

   vec_t tbl[8];

   program_memory_loader #(
      .MEMORY_DEPTH (DEPTH),
      .DATA_WIDTH   (DW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .Byte_i       (Byte_i),
      .Byte_Valid_i (Byte_Valid_i),
      .Byte_Ready_o (Byte_Ready_o),
      .Wr_En_o      (Wr_En_o),
      .Wr_Addr_o    (Wr_Addr_o),
      .Wr_Data_o    (Wr_Data_o),
      .Cpu_Reset_o  (Cpu_Reset_o),
      .Load_Done_o  (Load_Done_o),
      .Load_Error_o (Load_Error_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every write strobe with the cycle it appeared in
   always @(negedge clk) begin
      if (!reset && Wr_En_o) begin
         wa.push_back(Wr_Addr_o);
         wd.push_back(Wr_Data_o);
         wc.push_back(cyc);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Present one byte for one clock after `gap` idle clocks; returns #1 after the accepting edge
   task automatic put(input logic [7:0] b, input int unsigned gap);
      Byte_Valid_i = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      Byte_i       = b;
      Byte_Valid_i = 1'b1;
      @(posedge clk);
      #1;
      last_acc     = cyc;
      Byte_Valid_i = 1'b0;
   endtask

   function automatic vec_t mk(input logic [15:0] len, input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3, input int unsigned gap,
                               input bit junk, input bit done, input bit err, input int unsigned nwr);
      vec_t v;
      v.len      = len;
      v.w        = {w3, w2, w1, w0};
      v.gap      = gap;
      v.junk     = junk;
      v.exp_done = done;
      v.exp_err  = err;
      v.exp_nwr  = nwr;
      return v;
   endfunction

   task automatic run_frame(input vec_t v, input bit bad_chk, input int unsigned k);
      logic [7:0]  chk;
      logic [31:0] word;
      int unsigned lat_ref;
      chk     = '0;
      lat_ref = 0;
      wa.delete();
      wd.delete();
      wc.delete();
      if (v.junk) begin
         put(8'h00, v.gap);
         put(8'hFF, v.gap);
      end
      put(8'hA5, v.gap);
      check($sformatf("v%0d_sync_cpu_reset", k), 64'(Cpu_Reset_o), 64'd1);
      check($sformatf("v%0d_sync_done_err", k), {62'd0, Load_Done_o, Load_Error_o}, 64'd0);
      put(v.len[7:0], v.gap);
      put(v.len[15:8], v.gap);
      for (int unsigned i = 0; i < v.exp_nwr; i++) begin
         word = v.w[i];
         for (int unsigned b = 0; b < 4; b++) begin
            logic [7:0] by;
            by  = word[8*b +: 8];
            chk = chk ^ by;
            put(by, v.gap);
         end
      end
      lat_ref = last_acc;
`ifdef LOADER_CHECKSUM_EN
      if (v.exp_nwr > 0) put(bad_chk ? (chk ^ 8'h01) : chk, v.gap);
`else
      if (bad_chk) $display("note: checksum not compiled in");
`endif
      Byte_Valid_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check($sformatf("v%0d_num_writes", k), 64'(wa.size()), 64'(v.exp_nwr));
      check($sformatf("v%0d_done", k), 64'(Load_Done_o), 64'(v.exp_done));
      check($sformatf("v%0d_error", k), 64'(Load_Error_o), 64'(v.exp_err));
      check($sformatf("v%0d_cpu_reset", k), 64'(Cpu_Reset_o), 64'(!v.exp_done));
      check($sformatf("v%0d_ready", k), 64'(Byte_Ready_o), 64'd1);
      for (int unsigned i = 0; i < wa.size() && i < v.exp_nwr; i++) begin
         check($sformatf("v%0d_wr_addr%0d", k, i), 64'(wa[i]), 64'(i));
         check($sformatf("v%0d_wr_data%0d", k, i), 64'(wd[i]), 64'(v.w[i]));
         if (v.gap == 0 && i > 0)
            check($sformatf("v%0d_spacing%0d", k, i), 64'(wc[i] - wc[i-1]), 64'd4);
      end
      if (wc.size() > 0 && v.exp_nwr > 0)
         check($sformatf("v%0d_latency", k), 64'(wc[wc.size()-1]), 64'(lat_ref));
   endtask

   initial begin
      tbl[0] = mk(16'd1,   32'h00000013, 32'h0,        32'h0,        32'h0,        0, 0, 1, 0, 1);
      tbl[1] = mk(16'd3,   32'h11223344, 32'h55667788, 32'hA5A5A5A5, 32'h0,        0, 0, 1, 0, 3);
      tbl[2] = mk(16'd65,  32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 1, 0);
      tbl[3] = mk(16'd0,   32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 1, 0);
      tbl[4] = mk(16'd2,   32'hDEADBEEF, 32'h000000A5, 32'h0,        32'h0,        2, 1, 1, 0, 2);
      tbl[5] = mk(16'd2,   32'hDEADBEEF, 32'h000000A5, 32'h0,        32'h0,        0, 0, 1, 0, 2);
      tbl[6] = mk(16'd4,   32'h01020304, 32'hA5000000, 32'h00000000, 32'hFFFFFFFF, 1, 1, 1, 0, 4);
      tbl[7] = mk(16'h0100, 32'h0,       32'h0,        32'h0,        32'h0,        0, 0, 0, 1, 0);

      // Reset values while reset is held
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready",   64'(Byte_Ready_o), 64'd1);
      check("rst_wr_en",   64'(Wr_En_o),      64'd0);
      check("rst_wr_addr", 64'(Wr_Addr_o),    64'd0);
      check("rst_wr_data", 64'(Wr_Data_o),    64'd0);
      check("rst_cpu_rst", 64'(Cpu_Reset_o),  64'd1);
      check("rst_done",    64'(Load_Done_o),  64'd0);
      check("rst_error",   64'(Load_Error_o), 64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int unsigned k = 0; k < 8; k++) run_frame(tbl[k], 1'b0, k);

      // Reset after the second payload byte, then a fresh frame must load
      wa.delete();
      put(8'hA5, 0);
      put(8'h02, 0);
      put(8'h00, 0);
      put(8'h11, 0);
      put(8'h22, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_wr_en",   64'(Wr_En_o),      64'd0);
      check("mid_rst_wr_addr", 64'(Wr_Addr_o),    64'd0);
      check("mid_rst_wr_data", 64'(Wr_Data_o),    64'd0);
      check("mid_rst_cpu_rst", 64'(Cpu_Reset_o),  64'd1);
      check("mid_rst_done",    64'(Load_Done_o),  64'd0);
      check("mid_rst_error",   64'(Load_Error_o), 64'd0);
      check("mid_rst_ready",   64'(Byte_Ready_o), 64'd1);
      check("mid_rst_nowrite", 64'(wa.size()),    64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      run_frame(tbl[0], 1'b0, 20);

`ifdef LOADER_CHECKSUM_EN
      // Wrong checksum: word still written, frame rejected, core held in reset
      begin
         vec_t bad;
         bad          = tbl[0];
         bad.exp_done = 1'b0;
         bad.exp_err  = 1'b1;
         run_frame(bad, 1'b1, 30);
      end
      run_frame(tbl[1], 1'b0, 31);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
